dmem_io_bridge: RTL and testbench

DMEM_IO_BRIDGE -- requirements
Module: dmem_io_bridge

---
 rtl/dmem_io_bridge_pkg.sv | 37 +++
 rtl/dmem_io_bridge_tx_fifo.sv | 52 +++++
 rtl/dmem_io_bridge.sv | 115 +++++++++++
 tb/tb_dmem_io_bridge.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_io_bridge_pkg.sv
// Shared definitions for the data-memory / I/O bridge.
//   - FSM state encoding for the I/O access sequencer
//   - I/O register offsets (addr[3:0]) and STATUS bit positions
//   - default base of the memory-mapped I/O window
//   - status_word(): packs FIFO state into the STATUS read value
package dmem_io_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT_FULL
   } state_e;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_0000;

   localparam logic [3:0] OFS_DISPLAY = 4'h0;
   localparam logic [3:0] OFS_TX_DATA = 4'h4;
   localparam logic [3:0] OFS_STATUS  = 4'h8;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_CNT_LSB   = 2;
   localparam int STAT_CNT_MSB   = 7;

   // STATUS = {24'b0, count[5:0], empty, full}
   function automatic logic [31:0] status_word(input logic [5:0] cnt,
                                               input logic       empty,
                                               input logic       full);
      logic [31:0] w;
      w = '0;
      w[STAT_CNT_MSB:STAT_CNT_LSB] = cnt;
      w[STAT_EMPTY_BIT]            = empty;
      w[STAT_FULL_BIT]             = full;
      return w;
   endfunction

endpackage

// File: rtl/dmem_io_bridge_tx_fifo.sv
// tx_fifo: byte FIFO feeding the TX consumer.
//   clk/rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : enqueue a byte; ignored when full
//   pop       : dequeue head; ignored when empty
//   full/empty/count : occupancy, count is log2(DEPTH)+1 bits
//   head      : current head byte, 0 while empty
module tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [7:0]             push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [7:0]             head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          push_ok, pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   // Stale storage is never visible: head reads 0 whenever empty.
   assign head    = empty ? 8'h00 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally: DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/dmem_io_bridge.sv
// dmem_io_bridge: routes CPU data accesses either to RAM (pass-through)
// or to a small memory-mapped I/O block (DISPLAY, TX_DATA, STATUS).
//   clk, rst            : clock, synchronous active-high reset
//   addr/write_en/read_en/data_in : request; held by requester while busy
//   data_out, busy      : response; data valid on the cycle busy is low
//   ram_*               : RAM-side request/response
//   display             : DISPLAY register
//   tx_data/tx_valid/tx_ready : TX FIFO head handshake
module dmem_io_bridge
   import dmem_io_bridge_pkg::*;
#(
   parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        busy,
   output logic [31:0] ram_addr,
   output logic        ram_write_en,
   output logic        ram_read_en,
   output logic [31:0] ram_data_in,
   input  logic [31:0] ram_data_out,
   input  logic        ram_busy,
   output logic [31:0] display,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e        state;
   logic          io_sel, io_req, tx_wr, push, full, empty;
   logic [CW-1:0] count;
   logic [31:0]   io_rdata;

   assign io_sel = (addr[31:16] == IO_BASE[31:16]);
   assign io_req = io_sel && (write_en || read_en);
   // A write wins over a simultaneous read, so write_en alone selects the push.
   assign tx_wr  = write_en && (addr[3:0] == OFS_TX_DATA);

   // ACCESS pushes only if there is room; WAIT_FULL pushes on the first
   // cycle a slot is free (full is registered, so a pop lands one cycle earlier).
   assign push = !full && ((state == ST_ACCESS && io_sel && tx_wr) ||
                           state == ST_WAIT_FULL);

   assign ram_addr    = addr;
   assign ram_data_in = data_in;
   assign tx_valid    = !empty;

   always_comb begin
      case (addr[3:0])
         OFS_DISPLAY: io_rdata = display;
         OFS_STATUS:  io_rdata = status_word(6'(count), empty, full);
         default:     io_rdata = '0;
      endcase
   end

   always_comb begin
      ram_write_en = 1'b0;
      ram_read_en  = 1'b0;
      busy         = 1'b0;
      data_out     = '0;
      if (!io_sel) begin
         ram_write_en = write_en;
         ram_read_en  = read_en && !write_en;
         busy         = ram_busy;
         data_out     = ram_data_out;
      end else begin
         case (state)
            ST_IDLE:      busy = io_req;
            ST_ACCESS: begin
               busy     = tx_wr && full;
               data_out = io_rdata;
            end
            ST_WAIT_FULL: busy = full;
            default:      busy = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         display <= '0;
      end else begin
         case (state)
            ST_IDLE: if (io_req) state <= ST_ACCESS;
            ST_ACCESS: begin
               if (io_sel && write_en && addr[3:0] == OFS_DISPLAY) display <= data_in;
               state <= (io_sel && tx_wr && full) ? ST_WAIT_FULL : ST_IDLE;
            end
            ST_WAIT_FULL: if (!full) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (data_in[7:0]),
      .pop       (tx_ready),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .head      (tx_data)
   );

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Directed + randomized bench for dmem_io_bridge. The reference model is
// transaction level: a DISPLAY value and a byte queue for the TX FIFO.
module tb_dmem_io_bridge;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr, data_in, data_out, ram_addr, ram_data_in, ram_data_out, display;
   logic        write_en, read_en, busy, ram_write_en, ram_read_en, ram_busy;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;

   int          vectors = 0;
   int          errs    = 0;
   logic [31:0] display_m;
   logic [7:0]  q [$];

   dmem_io_bridge #(.IO_BASE(32'hFFFF_0000), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .addr(addr), .write_en(write_en), .read_en(read_en),
      .data_in(data_in), .data_out(data_out), .busy(busy), .ram_addr(ram_addr),
      .ram_write_en(ram_write_en), .ram_read_en(ram_read_en), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .ram_busy(ram_busy), .display(display),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] w;
      w = '0;
      w[7:2] = 6'(q.size());
      w[1]   = (q.size() == 0);
      w[0]   = (q.size() == D);
      return w;
   endfunction

   function automatic logic [31:0] exp_read(input logic [31:0] a);
      case (a[3:0])
         4'h0:    return display_m;
         4'h8:    return exp_status();
         default: return 32'h0;
      endcase
   endfunction

   // IO write to a non-full target: busy 1 cycle, then low; side effect next edge.
   task automatic io_write(input logic [31:0] a, input logic [31:0] d, input logic also_rd);
      addr = a; data_in = d; write_en = 1'b1; read_en = also_rd;
      #1 chk("io_wr_busy_idle", {31'b0, busy}, 32'h1);
      cyc();
      chk("io_wr_busy_access", {31'b0, busy}, 32'h0);
      cyc();
      write_en = 1'b0; read_en = 1'b0;
      if (a[3:0] == 4'h0) display_m = d;
      if (a[3:0] == 4'h4) q.push_back(d[7:0]);
      chk("io_wr_display", display, display_m);
   endtask

   task automatic io_read(input logic [31:0] a);
      logic [31:0] e;
      e = exp_read(a);
      addr = a; read_en = 1'b1; write_en = 1'b0;
      #1 chk("io_rd_busy_idle", {31'b0, busy}, 32'h1);
      cyc();
      chk("io_rd_busy_access", {31'b0, busy}, 32'h0);
      chk("io_rd_data", data_out, e);
      cyc();
      read_en = 1'b0;
   endtask

   task automatic pop_one();
      if (q.size() > 0) chk("pop_head", {24'b0, tx_data}, {24'b0, q[0]});
      chk("pop_valid", {31'b0, tx_valid}, {31'b0, q.size() > 0});
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
      if (q.size() > 0) void'(q.pop_front());
   endtask

   task automatic do_reset();
      rst = 1'b1; write_en = 1'b0; read_en = 1'b0; tx_ready = 1'b0;
      cyc();
      rst = 1'b0;
      display_m = '0;
      q.delete();
   endtask

   initial begin
      logic [31:0] a, d, rd;
      logic        we, re, rb;
      rst = 1'b1; addr = 32'hFFFF_0000; data_in = '0; write_en = 1'b0; read_en = 1'b0;
      ram_data_out = '0; ram_busy = 1'b0; tx_ready = 1'b0;
      display_m = '0;
      repeat (2) cyc();
      rst = 1'b0;
      #1;
      chk("rst_display", display, 32'h0);
      chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_data_out", data_out, 32'h0);

      // DISPLAY write and readback
      io_write(32'hFFFF_0000, 32'hDEAD_BEEF, 1'b0);
      io_read(32'hFFFF_0000);

      // RAM write: busy mirrors ram_busy, no IO side effects
      addr = 32'h0000_0040; data_in = 32'hCAFE_0001; write_en = 1'b1; ram_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("ram_busy_mirror", {31'b0, busy}, 32'h1);
         chk("ram_we", {31'b0, ram_write_en}, 32'h1);
         chk("ram_addr", ram_addr, 32'h0000_0040);
         cyc();
      end
      ram_busy = 1'b0;
      #1 chk("ram_busy_low", {31'b0, busy}, 32'h0);
      chk("ram_display_kept", display, display_m);
      cyc();
      write_en = 1'b0;

      // Fill the FIFO, then a fifth push stalls until a slot frees
      for (int i = 0; i < 4; i++) io_write(32'hFFFF_0004, 32'h41 + i, 1'b0);
      io_read(32'hFFFF_0008);
      addr = 32'hFFFF_0004; data_in = 32'h45; write_en = 1'b1;
      #1 chk("wf_busy_idle", {31'b0, busy}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("wf_busy_held", {31'b0, busy}, 32'h1);
      end
      chk("wf_head", {24'b0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      cyc();
      tx_ready = 1'b0;
      void'(q.pop_front());
      chk("wf_busy_release", {31'b0, busy}, 32'h0);
      cyc();
      write_en = 1'b0;
      q.push_back(8'h45);
      while (q.size() > 0) pop_one();
      chk("wf_drained", {31'b0, tx_valid}, 32'h0);

      // Push and pop in the same cycle keep the count
      io_write(32'hFFFF_0004, 32'h41, 1'b0);
      io_write(32'hFFFF_0004, 32'h42, 1'b0);
      addr = 32'hFFFF_0004; data_in = 32'h55; write_en = 1'b1;
      cyc();
      tx_ready = 1'b1;
      chk("pp_head", {24'b0, tx_data}, 32'h41);
      cyc();
      tx_ready = 1'b0; write_en = 1'b0;
      void'(q.pop_front());
      q.push_back(8'h55);
      io_read(32'hFFFF_0008);

      // Unmapped offset reads 0; write beats read when both are set
      io_read(32'hFFFF_000C);
      io_write(32'hFFFF_000C, 32'h1111_2222, 1'b0);
      io_write(32'hFFFF_0000, 32'hA5A5_5A5A, 1'b1);

      // Reset in ACCESS of a DISPLAY write
      addr = 32'hFFFF_0000; data_in = 32'h1234_5678; write_en = 1'b1;
      cyc();
      do_reset();
      chk("ra_display", display, 32'h0);
      chk("ra_busy", {31'b0, busy}, 32'h0);
      chk("ra_tx_valid", {31'b0, tx_valid}, 32'h0);

      // Reset while stalled in WAIT_FULL
      for (int i = 0; i < 4; i++) io_write(32'hFFFF_0004, 32'h60 + i, 1'b0);
      addr = 32'hFFFF_0004; data_in = 32'h77; write_en = 1'b1;
      repeat (3) cyc();
      chk("rw_busy", {31'b0, busy}, 32'h1);
      do_reset();
      chk("rw_tx_valid", {31'b0, tx_valid}, 32'h0);
      io_read(32'hFFFF_0008);

      // Randomized mix against the transaction model
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 6))
            0: io_write(32'hFFFF_0000, $urandom, 1'($urandom_range(0, 1)));
            1: if (q.size() < D) io_write(32'hFFFF_0004, $urandom, 1'b0);
            2: pop_one();
            3: io_read({28'hFFFF_000, 4'($urandom_range(0, 15))});
            4: io_write({28'hFFFF_000, 4'(4'h8 + $urandom_range(0, 7))}, $urandom, 1'b0);
            default: begin
               a = $urandom;
               if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
               d = $urandom; rd = $urandom;
               we = 1'($urandom_range(0, 1)); re = 1'($urandom_range(0, 1));
               rb = 1'($urandom_range(0, 1));
               addr = a; data_in = d; write_en = we; read_en = re;
               ram_data_out = rd; ram_busy = rb;
               #1;
               chk("rnd_ram_addr", ram_addr, a);
               chk("rnd_ram_din", ram_data_in, d);
               chk("rnd_ram_we", {31'b0, ram_write_en}, {31'b0, we});
               chk("rnd_ram_re", {31'b0, ram_read_en}, {31'b0, re && !we});
               chk("rnd_ram_busy", {31'b0, busy}, {31'b0, rb});
               chk("rnd_ram_dout", data_out, rd);
               cyc();
               write_en = 1'b0; read_en = 1'b0; ram_busy = 1'b0;
               chk("rnd_ram_display", display, display_m);
            end
         endcase
         chk("rnd_status", {29'b0, tx_valid, 2'b0}, {29'b0, q.size() > 0, 2'b0});
      end
      io_read(32'hFFFF_0008);
      io_read(32'hFFFF_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
